// File: rtl/cic_pkg.sv
// Shared CIC helpers: width arithmetic and the round/saturate step used by
// both the decimator and the planned interpolator.
package cic_pkg;

    localparam int MAX_STAGES = 6;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int in_w, input int n, input int r, input int m);
        return in_w + n * clog2(r * m);
    endfunction

    // Drop (acc_w - out_w) LSBs with round-half-up, then clamp the positive side.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                     input int acc_w,
                                                     input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] max_val;
        int d;
        d = acc_w - out_w;
        if (d > 0) begin
            r = (v + (64'sd1 <<< (d - 1))) >>> d;
        end else begin
            r = v;
        end
        max_val = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        if (r > max_val) begin
            r = max_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: y = x - x delayed by M decimated samples, advancing
// only when en is high.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = 19,
    parameter int M = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);

    logic signed [W-1:0] delay_reg [M];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                delay_reg[k] <= '0;
            end
            dout <= '0;
        end else if (en) begin
            delay_reg[0] <= din;
            for (int k = 1; k < M; k++) begin
                delay_reg[k] <= delay_reg[k-1];
            end
            dout <= din - delay_reg[M-1];
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at input rate, decimate-by-R strobe,
// comb pipeline at output rate, then round-half-up and positive saturation.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int N     = 3,
    parameter int R     = 8,
    parameter int M     = 1,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data
);

    localparam int ACC_W = acc_width(IN_W, N, R, M);
    localparam int PH_W  = (clog2(R) > 0) ? clog2(R) : 1;

    logic signed [ACC_W-1:0] integ_reg [N];
    logic [PH_W-1:0]         phase_reg;
    logic                    dec;
    logic signed [ACC_W-1:0] in_ext;

    logic                    dec_reg;
    logic                    cap_valid_reg;
    logic signed [ACC_W-1:0] cap_reg;
    logic [N-1:0]            stage_valid_reg;
    logic [N:0]              en_vec;
    logic signed [ACC_W-1:0] comb_data [N+1];
    logic signed [63:0]      comb_wide;
    logic signed [OUT_W-1:0] rounded;

    assign in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    assign dec    = in_valid && (phase_reg == PH_W'(R - 1));

    // Integrators wrap freely in ACC_W bits; the combs cancel the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                integ_reg[i] <= '0;
            end
            phase_reg <= '0;
        end else if (in_valid) begin
            integ_reg[0] <= integ_reg[0] + in_ext;
            for (int i = 1; i < N; i++) begin
                integ_reg[i] <= integ_reg[i] + integ_reg[i-1];
            end
            phase_reg <= dec ? '0 : phase_reg + PH_W'(1);
        end
    end

    // dec_reg marks the cycle in which the last integrator already holds the
    // decimated sample, so capture happens one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_reg         <= 1'b0;
            cap_valid_reg   <= 1'b0;
            cap_reg         <= '0;
            stage_valid_reg <= '0;
        end else begin
            dec_reg         <= dec;
            cap_valid_reg   <= dec_reg;
            stage_valid_reg <= en_vec[N-1:0];
            if (dec_reg) begin
                cap_reg <= integ_reg[N-1];
            end
        end
    end

    assign en_vec       = {stage_valid_reg, cap_valid_reg};
    assign comb_data[0] = cap_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_comb
            cic_comb_stage #(
                .W (ACC_W),
                .M (M)
            ) u_comb (
                .clk  (clk),
                .rst  (rst),
                .en   (en_vec[gi]),
                .din  (comb_data[gi]),
                .dout (comb_data[gi+1])
            );
        end
    endgenerate

    assign comb_wide = {{(64-ACC_W){comb_data[N][ACC_W-1]}}, comb_data[N]};
    assign rounded   = OUT_W'(round_sat(comb_wide, ACC_W, OUT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= en_vec[N];
            if (en_vec[N]) begin
                out_data <= rounded;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: a sample-domain reference model pushes
// expected outputs with their due cycle; monitors pop and compare.
module tb_cic_decimator;

    localparam int IN_W  = 10;
    localparam int N     = 3;
    localparam int R     = 8;
    localparam int M     = 1;
    localparam int OUT_W = 16;
    localparam int ACC_W = 19;
    localparam int D     = ACC_W - OUT_W;
    localparam int LAT   = N + 2;
    localparam longint MAXO = 32767;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b1;
    logic signed [IN_W-1:0] in_data = 10'sd511;
    logic out_valid;
    logic signed [OUT_W-1:0] out_data;

    logic in_valid2 = 1'b0;
    logic signed [3:0] in_data2 = '0;
    logic out_valid2;
    logic signed [3:0] out_data2;

    always #5 clk = ~clk;

    cic_decimator #(.IN_W(IN_W), .N(N), .R(R), .M(M), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data)
    );

    cic_decimator #(.IN_W(4), .N(1), .R(2), .M(1), .OUT_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
        .out_valid(out_valid2), .out_data(out_data2)
    );

    typedef struct {
        longint val;
        int     due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    longint log_q[$];
    longint gapfree[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic rst_q = 1'b0;

    longint integ_m [N];
    longint hist_m [N][M];
    int phase_m = 0;
    longint prev2 = 0;
    int phase2 = 0;

    longint last_out = 0;
    longint last_out2 = 0;
    int last_pulse = -1;
    int last_pulse2 = -1;
    bit have_out = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(posedge clk) begin
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycle=%0d limit=50000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic longint wrapa(input longint v);
        longint m;
        m = v & ((longint'(1) <<< ACC_W) - 1);
        if (m >= (longint'(1) <<< (ACC_W - 1))) m = m - (longint'(1) <<< ACC_W);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            integ_m[i] = 0;
            for (int k = 0; k < M; k++) hist_m[i][k] = 0;
        end
        phase_m = 0;
        prev2 = 0;
        phase2 = 0;
    endtask

    // Sample-domain reference: integrator recurrences per accepted sample,
    // combs evaluated once every R samples, then scaling arithmetic.
    task automatic model_accept(input longint x, input int due);
        longint nxt [N];
        longint c, y, val;
        exp_t e;
        nxt[0] = wrapa(integ_m[0] + x);
        for (int i = 1; i < N; i++) nxt[i] = wrapa(integ_m[i] + integ_m[i-1]);
        for (int i = 0; i < N; i++) integ_m[i] = nxt[i];
        if (phase_m == R - 1) begin
            phase_m = 0;
            c = integ_m[N-1];
            for (int j = 0; j < N; j++) begin
                y = wrapa(c - hist_m[j][M-1]);
                for (int k = M - 1; k > 0; k--) hist_m[j][k] = hist_m[j][k-1];
                hist_m[j][0] = c;
                c = y;
            end
            val = (c + (longint'(1) <<< (D - 1))) >>> D;
            if (val > MAXO) val = MAXO;
            e.val = val;
            e.due = due;
            q1.push_back(e);
        end else begin
            phase_m++;
        end
    endtask

    // Second instance (N=1, R=2, M=1, D=1): output is the rounded pair sum.
    task automatic model2_accept(input longint x, input int due);
        longint val;
        exp_t e;
        if (phase2 == 1) begin
            val = (prev2 + x + 1) >>> 1;
            if (val > 7) val = 7;
            e.val = val;
            e.due = due;
            q2.push_back(e);
            phase2 = 0;
        end else begin
            prev2 = x;
            phase2 = 1;
        end
    endtask

    task automatic drive(input bit v, input int x);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = IN_W'(x);
        if (v) model_accept(longint'(x), cyc + 1 + LAT);
    endtask

    task automatic drive2(input bit v, input int x);
        @(posedge clk);
        #1;
        in_valid2 = v;
        in_data2  = 4'(x);
        if (v) model2_accept(longint'(x), cyc + 1 + 3);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0);
    endtask

    task automatic apply_reset(input int cycles, input bit v, input int x);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = v;
        in_data = IN_W'(x);
        in_valid2 = 1'b0;
        while (q1.size() > 0 && q1[q1.size()-1].due > cyc) void'(q1.pop_back());
        while (q2.size() > 0 && q2[q2.size()-1].due > cyc) void'(q2.pop_back());
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            check("rst_out_valid", longint'(out_valid), 0);
            check("rst_out_data", longint'(out_data), 0);
            last_out = 0;
            last_pulse = -1;
            have_out = 1;
        end else if (out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("spurious_out_valid", longint'(out_valid), 0);
            end else begin
                e = q1.pop_front();
                check("out_data", longint'(out_data), e.val);
                check("latency_cycle", longint'(cyc), longint'(e.due));
                if (last_pulse >= 0) check("spacing_ge_R", longint'((cyc - last_pulse) >= R), 1);
                $display("out #%0d cycle=%0d data=%0d", log_q.size(), cyc, out_data);
            end
            last_pulse = cyc;
            last_out = longint'(out_data);
            log_q.push_back(longint'(out_data));
        end else if (have_out) begin
            check("out_data_hold", longint'(out_data), last_out);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            check("rst2_out_valid", longint'(out_valid2), 0);
            last_out2 = 0;
            last_pulse2 = -1;
        end else if (out_valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("spurious_out_valid2", longint'(out_valid2), 0);
            end else begin
                e = q2.pop_front();
                check("out_data2", longint'(out_data2), e.val);
                check("latency_cycle2", longint'(cyc), longint'(e.due));
                if (last_pulse2 >= 0) check("spacing2_ge_R", longint'((cyc - last_pulse2) >= 2), 1);
                $display("out2 cycle=%0d data=%0d", cyc, out_data2);
            end
            last_pulse2 = cyc;
            last_out2 = longint'(out_data2);
        end
    end

    initial begin
        int acc;
        int iter;
        model_reset();
        // Reset held 3 cycles with a valid sample present; nothing is accepted.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        // DC step 100 -> 100 * 512 / 8
        for (int i = 0; i < 64; i++) drive(1'b1, 100);
        idle(LAT + 3);
        check("dc_100", last_out, 6400);
        for (int i = 0; i < log_q.size(); i++) gapfree.push_back(log_q[i]);

        for (int i = 0; i < 64; i++) drive(1'b1, -512);
        idle(LAT + 3);
        check("dc_neg512", last_out, -32768);

        // Long run at full scale: integrators wrap many times over.
        apply_reset(2, 1'b1, 511);
        for (int i = 0; i < 1200; i++) drive(1'b1, 511);
        idle(LAT + 3);
        check("dc_511_wrap", last_out, 32704);

        // Same DC 100 stimulus with random gaps.
        apply_reset(1, 1'b0, 0);
        log_q.delete();
        acc = 0;
        iter = 0;
        while (acc < 64 && iter < 1000) begin
            iter++;
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, 100);
                acc++;
            end else begin
                drive(1'b0, int'($urandom_range(0, 1023)) - 512);
            end
        end
        check("gap_loop_bound", longint'(acc), 64);
        idle(LAT + 3);
        check("gap_count", longint'(log_q.size()), longint'(gapfree.size()));
        for (int i = 0; i < gapfree.size() && i < log_q.size(); i++) begin
            check("gap_seq", log_q[i], gapfree[i]);
        end

        // Random data, random valid.
        apply_reset(1, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)) - 512);
        end
        idle(LAT + 3);

        // Reset lands while a decimated output is in flight.
        apply_reset(1, 1'b0, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 300);
        apply_reset(1, 1'b1, 511);
        idle(10);
        for (int i = 0; i < 24; i++) drive(1'b1, 200);
        idle(LAT + 3);

        // Rounding instance: half-up on +3.5 and -3.5.
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, 7);
            drive2(1'b1, 0);
        end
        drive2(1'b0, 0);
        repeat (5) drive2(1'b0, 0);
        check("round_pos", last_out2, 4);
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, -7);
            drive2(1'b1, 0);
        end
        repeat (6) drive2(1'b0, 0);
        check("round_neg", last_out2, -3);
        for (int i = 0; i < 100; i++) begin
            drive2(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)) - 8);
        end
        drive2(1'b0, 0);

        iter = 0;
        while ((q1.size() + q2.size()) > 0 && iter < 50) begin
            @(posedge clk);
            iter++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard_drained", longint'(q1.size() + q2.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
